// File: rtl/vga_timing_pkg.sv
// rtl/vga_timing_pkg.sv - timing constants and helpers shared by the VGA timing generator
package vga_timing_pkg;

    // 640x480@60, 25 MHz pixel rate
    localparam int VGA640_H_ACTIVE = 640;
    localparam int VGA640_H_FP     = 16;
    localparam int VGA640_H_SYNC   = 96;
    localparam int VGA640_H_BP     = 48;
    localparam int VGA640_V_ACTIVE = 480;
    localparam int VGA640_V_FP     = 10;
    localparam int VGA640_V_SYNC   = 2;
    localparam int VGA640_V_BP     = 33;

    // 800x600@72, 50 MHz pixel rate (50 MHz board)
    localparam int SVGA800_H_ACTIVE = 800;
    localparam int SVGA800_H_FP     = 56;
    localparam int SVGA800_H_SYNC   = 120;
    localparam int SVGA800_H_BP     = 64;
    localparam int SVGA800_V_ACTIVE = 600;
    localparam int SVGA800_V_FP     = 37;
    localparam int SVGA800_V_SYNC   = 6;
    localparam int SVGA800_V_BP     = 23;

    // Total length of one axis: active area plus both porches plus sync
    function automatic int axis_total(input int active, input int fp, input int sync, input int bp);
        return active + fp + sync + bp;
    endfunction

    localparam int VGA640_H_TOTAL  = axis_total(VGA640_H_ACTIVE, VGA640_H_FP, VGA640_H_SYNC, VGA640_H_BP);
    localparam int VGA640_V_TOTAL  = axis_total(VGA640_V_ACTIVE, VGA640_V_FP, VGA640_V_SYNC, VGA640_V_BP);
    localparam int SVGA800_H_TOTAL = axis_total(SVGA800_H_ACTIVE, SVGA800_H_FP, SVGA800_H_SYNC, SVGA800_H_BP);
    localparam int SVGA800_V_TOTAL = axis_total(SVGA800_V_ACTIVE, SVGA800_V_FP, SVGA800_V_SYNC, SVGA800_V_BP);

endpackage

// File: rtl/vga_axis_counter.sv
// rtl/vga_axis_counter.sv - one timing axis: wrapping position counter with registered blank and sync decode
module vga_axis_counter #(
    parameter int TOTAL      = 800,
    parameter int ACTIVE     = 640,
    parameter int SYNC_START = 656,
    parameter int SYNC_LEN   = 96,
    parameter int CW         = 10
) (
    input  logic          clk,
    input  logic          clr,
    input  logic          en,
    output logic [CW-1:0] count,
    output logic          wrap,
    output logic          blank,
    output logic          sync
);

    localparam logic [CW-1:0] LAST = CW'(TOTAL - 1);
    // Decode limits carry one extra bit so a sync window ending exactly at 2^CW still compares correctly
    localparam logic [CW:0] ACT_LIM  = (CW+1)'(ACTIVE);
    localparam logic [CW:0] SYNC_LO  = (CW+1)'(SYNC_START);
    localparam logic [CW:0] SYNC_HI  = (CW+1)'(SYNC_START + SYNC_LEN);

    logic [CW-1:0] nxt;
    logic [CW:0]   nxt_ext;

    // wrap flags that the next enabled edge returns the counter to 0
    assign wrap    = (count == LAST);
    assign nxt     = wrap ? '0 : count + 1'b1;
    assign nxt_ext = {1'b0, nxt};

    // Advance on enable; blank and sync are decoded from the value being loaded so they track count exactly
    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            count <= LAST;
            blank <= 1'b1;
            sync  <= 1'b0;
        end else if (en) begin
            count <= nxt;
            blank <= (nxt_ext >= ACT_LIM);
            sync  <= (nxt_ext >= SYNC_LO) && (nxt_ext < SYNC_HI);
        end
    end

endmodule

// File: rtl/vga_timing_gen.sv
// rtl/vga_timing_gen.sv - parametrised VGA timing generator; optional frame counter under VTG_FRAME_CNT_EN
module vga_timing_gen
    import vga_timing_pkg::*;
#(
    parameter int H_ACTIVE = VGA640_H_ACTIVE,
    parameter int H_FP     = VGA640_H_FP,
    parameter int H_SYNC   = VGA640_H_SYNC,
    parameter int H_BP     = VGA640_H_BP,
    parameter int V_ACTIVE = VGA640_V_ACTIVE,
    parameter int V_FP     = VGA640_V_FP,
    parameter int V_SYNC   = VGA640_V_SYNC,
    parameter int V_BP     = VGA640_V_BP,
    parameter int HS_POL   = 0,
    parameter int VS_POL   = 0,
    parameter int CW       = 10
) (
    input  logic          clk,
    input  logic          clr,
    input  logic          pix_ce,
    output logic          hsync,
    output logic          vsync,
    output logic          video_on,
    output logic          hblank,
    output logic          vblank,
    output logic [CW-1:0] pixel_x,
    output logic [CW-1:0] pixel_y,
    output logic          line_start,
`ifdef VTG_FRAME_CNT_EN
    output logic [15:0]   frame_cnt,
`endif
    output logic          frame_start
);

    localparam int H_TOTAL = axis_total(H_ACTIVE, H_FP, H_SYNC, H_BP);
    localparam int V_TOTAL = axis_total(V_ACTIVE, V_FP, V_SYNC, V_BP);
    localparam logic [CW-1:0] H_ACT_C = CW'(H_ACTIVE);
    localparam logic [CW-1:0] V_ACT_C = CW'(V_ACTIVE);

    logic [CW-1:0] h_count, v_count;
    logic          h_wrap, v_wrap, h_blank, v_blank, h_sync, v_sync;
    logic [CW-1:0] h_after, v_after;

    vga_axis_counter #(
        .TOTAL(H_TOTAL), .ACTIVE(H_ACTIVE), .SYNC_START(H_ACTIVE + H_FP), .SYNC_LEN(H_SYNC), .CW(CW)
    ) u_h (
        .clk(clk), .clr(clr), .en(pix_ce),
        .count(h_count), .wrap(h_wrap), .blank(h_blank), .sync(h_sync)
    );

    vga_axis_counter #(
        .TOTAL(V_TOTAL), .ACTIVE(V_ACTIVE), .SYNC_START(V_ACTIVE + V_FP), .SYNC_LEN(V_SYNC), .CW(CW)
    ) u_v (
        .clk(clk), .clr(clr), .en(pix_ce & h_wrap),
        .count(v_count), .wrap(v_wrap), .blank(v_blank), .sync(v_sync)
    );

    // Position the axes will hold after the next ce edge, used to pre-decode the coordinate outputs
    assign h_after = h_wrap ? '0 : h_count + 1'b1;
    assign v_after = h_wrap ? (v_wrap ? '0 : v_count + 1'b1) : v_count;

    // Polarity is a constant, so these stay straight register outputs
    assign hsync  = (HS_POL != 0) ? h_sync : ~h_sync;
    assign vsync  = (VS_POL != 0) ? v_sync : ~v_sync;
    assign hblank = h_blank;
    assign vblank = v_blank;

    // Coordinates and strobes; strobes are rewritten every clk so they last exactly one cycle
    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            video_on    <= 1'b0;
            pixel_x     <= '0;
            pixel_y     <= '0;
            line_start  <= 1'b0;
            frame_start <= 1'b0;
`ifdef VTG_FRAME_CNT_EN
            frame_cnt   <= '0;
`endif
        end else begin
            line_start  <= pix_ce & h_wrap;
            frame_start <= pix_ce & h_wrap & v_wrap;
            if (pix_ce) begin
                video_on <= (h_after < H_ACT_C) && (v_after < V_ACT_C);
                pixel_x  <= (h_after < H_ACT_C) ? h_after : '0;
                pixel_y  <= (v_after < V_ACT_C) ? v_after : '0;
`ifdef VTG_FRAME_CNT_EN
                if (h_wrap && v_wrap) begin
                    frame_cnt <= frame_cnt + 16'd1;
                end
`endif
            end
        end
    end

endmodule

// File: tb/tb_vga_timing_gen.sv
// tb/tb_vga_timing_gen.sv - randomized self-checking bench for vga_timing_gen against an arithmetic reference
module tb_vga_timing_gen;

    localparam int AHA = 640, AHF = 16, AHS = 96, AHB = 48;
    localparam int AVA = 480, AVF = 10, AVS = 2,  AVB = 33;
    localparam int AHT = AHA + AHF + AHS + AHB;
    localparam int AVT = AVA + AVF + AVS + AVB;
    localparam int BHA = 10, BHF = 2, BHS = 3, BHB = 4;
    localparam int BVA = 6,  BVF = 1, BVS = 2, BVB = 2;
    localparam int BHT = BHA + BHF + BHS + BHB;
    localparam int BVT = BVA + BVF + BVS + BVB;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic clr = 1'b1;
    logic pix_ce = 1'b0;

    logic       a_hsync, a_vsync, a_video_on, a_hblank, a_vblank, a_line_start, a_frame_start;
    logic [9:0] a_px, a_py;
    logic       b_hsync, b_vsync, b_video_on, b_hblank, b_vblank, b_line_start, b_frame_start;
    logic [9:0] b_px, b_py;
`ifdef VTG_FRAME_CNT_EN
    logic [15:0] a_fc, b_fc;
`endif

    vga_timing_gen dut_a (
        .clk(clk), .clr(clr), .pix_ce(pix_ce),
        .hsync(a_hsync), .vsync(a_vsync), .video_on(a_video_on),
        .hblank(a_hblank), .vblank(a_vblank), .pixel_x(a_px), .pixel_y(a_py),
        .line_start(a_line_start),
`ifdef VTG_FRAME_CNT_EN
        .frame_cnt(a_fc),
`endif
        .frame_start(a_frame_start)
    );

    vga_timing_gen #(
        .H_ACTIVE(BHA), .H_FP(BHF), .H_SYNC(BHS), .H_BP(BHB),
        .V_ACTIVE(BVA), .V_FP(BVF), .V_SYNC(BVS), .V_BP(BVB),
        .HS_POL(1), .VS_POL(1), .CW(10)
    ) dut_b (
        .clk(clk), .clr(clr), .pix_ce(pix_ce),
        .hsync(b_hsync), .vsync(b_vsync), .video_on(b_video_on),
        .hblank(b_hblank), .vblank(b_vblank), .pixel_x(b_px), .pixel_y(b_py),
        .line_start(b_line_start),
`ifdef VTG_FRAME_CNT_EN
        .frame_cnt(b_fc),
`endif
        .frame_start(b_frame_start)
    );

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;
    int ahc, avc, bhc, bvc, afc, bfc;
    bit als, afs, bls, bfs;
    int b_fs_seen = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            if (n_fail <= 30)
                $display("FAIL %s @cyc %0d: got %h expected %h", tag, cyc, got, exp);
        end
    endtask

    // Expected outputs from the position on each axis, straight from the timing rules
    function automatic logic [26:0] expv(input int hc, input int vc,
                                         input int ha, input int hf, input int hs,
                                         input int va, input int vf, input int vs,
                                         input bit hp, input bit vp, input bit ls, input bit fs);
        bit h_in, v_in;
        h_in = (hc >= ha + hf) && (hc < ha + hf + hs);
        v_in = (vc >= va + vf) && (vc < va + vf + vs);
        return {h_in ? hp : !hp, v_in ? vp : !vp, (hc < ha) && (vc < va),
                hc >= ha, vc >= va,
                10'((hc < ha) ? hc : 0), 10'((vc < va) ? vc : 0), ls, fs};
    endfunction

    task automatic model_reset();
        ahc = AHT - 1; avc = AVT - 1; bhc = BHT - 1; bvc = BVT - 1;
        als = 0; afs = 0; bls = 0; bfs = 0; afc = 0; bfc = 0;
        b_fs_seen = 0;
    endtask

    task automatic adv(inout int hc, inout int vc, input int ht, input int vt,
                       input bit ce, output bit ls, output bit fs);
        ls = 0; fs = 0;
        if (ce) begin
            hc = (hc + 1) % ht;
            if (hc == 0) vc = (vc + 1) % vt;
            ls = (hc == 0);
            fs = ls && (vc == 0);
        end
    endtask

    task automatic compare_all();
        check("a_out", 64'({a_hsync, a_vsync, a_video_on, a_hblank, a_vblank, a_px, a_py, a_line_start, a_frame_start}),
              64'(expv(ahc, avc, AHA, AHF, AHS, AVA, AVF, AVS, 1'b0, 1'b0, als, afs)));
        check("b_out", 64'({b_hsync, b_vsync, b_video_on, b_hblank, b_vblank, b_px, b_py, b_line_start, b_frame_start}),
              64'(expv(bhc, bvc, BHA, BHF, BHS, BVA, BVF, BVS, 1'b1, 1'b1, bls, bfs)));
`ifdef VTG_FRAME_CNT_EN
        check("a_fc", 64'(a_fc), 64'(afc));
        check("b_fc", 64'(b_fc), 64'(bfc));
`endif
    endtask

    task automatic step(input bit ce);
        pix_ce = ce;
        @(posedge clk);
        #1;
        cyc++;
        adv(ahc, avc, AHT, AVT, ce, als, afs);
        adv(bhc, bvc, BHT, BVT, ce, bls, bfs);
        if (afs) afc = (afc + 1) % 65536;
        if (bfs) bfc = (bfc + 1) % 65536;
        compare_all();
        if (b_frame_start) begin
            b_fs_seen++;
`ifdef VTG_FRAME_CNT_EN
            if (b_fs_seen == 3) check("b_fc_third", 64'(b_fc), 64'd3);
`endif
        end
    endtask

    initial begin
        int von, hsl, first_hs, ls_cnt, last_ls, per, guard;
        clr = 1'b1;
        pix_ce = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        clr = 1'b0;
        model_reset();
        compare_all();
        check("rst_a_hsync", 64'(a_hsync), 64'd1);
        check("rst_a_vsync", 64'(a_vsync), 64'd1);
        check("rst_b_hsync", 64'(b_hsync), 64'd0);
        check("rst_a_blank", 64'({a_video_on, a_hblank, a_vblank}), 64'b011);
        repeat (3) step(1'b0);

        // Continuous ce: one full default line
        von = 0; hsl = 0; first_hs = -1;
        for (int i = 0; i < AHT; i++) begin
            step(1'b1);
            if (i == 0) check("first_fs", 64'({a_frame_start, a_line_start, a_px}), 64'({1'b1, 1'b1, 10'd0}));
            if (a_video_on) von++;
            if (!a_hsync) begin
                if (first_hs < 0) first_hs = i;
                hsl++;
            end
        end
        check("von_len", 64'(von), 64'd640);
        check("hs_len", 64'(hsl), 64'd96);
        check("hs_start", 64'(first_hs), 64'd656);
        ls_cnt = 0;
        for (int i = 0; i < AHT; i++) begin
            step(1'b1);
            if (a_line_start) ls_cnt++;
        end
        check("ls_per_line", 64'(ls_cnt), 64'd1);

        // ce 1-in-4: line period in clks
        last_ls = -1; per = 0;
        for (int i = 0; i < 3 * 4 * AHT; i++) begin
            step(i % 4 == 0);
            if (a_line_start) begin
                if (last_ls >= 0 && per == 0) per = cyc - last_ls;
                last_ls = cyc;
            end
        end
        check("ls_period", 64'(per), 64'd3200);

        // Random ce density
        for (int i = 0; i < 20000; i++) step($urandom_range(0, 3) != 0);

        // Move the small instance to mid-frame, then clear asynchronously
        guard = 0;
        while (!(bhc == 5 && bvc == 3) && guard < 400) begin
            step(1'b1);
            guard++;
        end
        check("mid_frame_reach", 64'(guard < 400), 64'd1);
        @(negedge clk);
        clr = 1'b1;
        #1;
        model_reset();
        compare_all();
        check("clr_async_b_px", 64'(b_px), 64'd0);
        @(posedge clk);
        #1;
        compare_all();
        clr = 1'b0;
        step(1'b0);
        step(1'b1);
        check("post_clr_fs", 64'({b_frame_start, b_px, a_frame_start, a_px}), 64'({1'b1, 10'd0, 1'b1, 10'd0}));

        for (int i = 0; i < 10000; i++) step($urandom_range(0, 1) != 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/vga_timing_gen.md
# vga_timing_gen

Parametrised VGA timing generator: the next-generation replacement for the fixed 640x480 sync block. Horizontal and vertical counters are driven by a pixel clock-enable, so the block runs from the system clock without a separate pixel clock. Per-axis porch, sync and active lengths and sync polarity are parameters. All outputs are registered, and the block also produces blanking flags and single-cycle line/frame start strobes for the game renderer and sprite fetch logic.

## Interface
- H_ACTIVE, 640, visible pixels per line
- H_FP, 16, horizontal front porch (pixels)
- H_SYNC, 96, hsync width (pixels)
- H_BP, 48, horizontal back porch (pixels)
- V_ACTIVE, 480, visible lines per frame
- V_FP, 10, vertical front porch (lines)
- V_SYNC, 2, vsync width (lines)
- V_BP, 33, vertical back porch (lines)
- HS_POL, 0, hsync active level (0 = active-low)
- VS_POL, 0, vsync active level
- CW, 10, counter and coordinate width; H_TOTAL and V_TOTAL must each be ≤ 2^CW
- clk  in  1  system clock
- clr  in  1  reset, asynchronous, active-high
- pix_ce  in  1  pixel clock-enable; counters advance only on clk edges with pix_ce=1
- hsync  out  1  horizontal sync, level set by HS_POL
- vsync  out  1  vertical sync, level set by VS_POL
- video_on  out  1  current pixel is in the active area
- hblank  out  1  hc ≥ H_ACTIVE
- vblank  out  1  vc ≥ V_ACTIVE
- pixel_x  out  CW  active column; 0 while hblank
- pixel_y  out  CW  active row; 0 while vblank
- line_start  out  1  one-clk strobe when hc becomes 0
- frame_start  out  1  one-clk strobe when hc and vc both become 0
- frame_cnt  out  16  frames started (present only with VTG_FRAME_CNT_EN)

## Operation
- H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP. V_TOTAL is defined the same way. Defaults give 800 × 525.
- Counter origin is the first active pixel:
  - hc 0..H_ACTIVE-1 is active, followed by front porch, then sync, then back porch.
  - vc uses the same ordering.
- On a clk edge with pix_ce=1:
  - hc = (hc == H_TOTAL-1) ? 0 : hc+1.
  - vc advances only when hc wraps: (vc == V_TOTAL-1) ? 0 : vc+1.
- hsync is active while H_ACTIVE+H_FP ≤ hc < H_ACTIVE+H_FP+H_SYNC. vsync is active over the same window on vc, using the V_* parameters.
- video_on = !hblank && !vblank.
- Arithmetic is unsigned CW-bit. Comparisons are made against constants sized to CW.

## Timing
- Outputs are registers, decoded from the next-state counter values. They always describe the current hc/vc and hold between pix_ce edges.
- line_start and frame_start:
  - Set on the ce edge that loads hc=0 (frame_start only when vc also becomes 0).
  - Cleared on the following clk edge regardless of pix_ce, so each is exactly 1 clk wide.
- Reset state is hc=H_TOTAL-1, vc=V_TOTAL-1. The first pix_ce after reset produces (0,0) together with line_start=1 and frame_start=1.
- Output reset values:
  - hsync=~HS_POL, vsync=~VS_POL.
  - video_on=0, hblank=1, vblank=1.
  - pixel_x=0, pixel_y=0.
  - line_start=0, frame_start=0, frame_cnt=0.
- clr mid-frame returns immediately to the reset state. No partial frame is flagged.
- pix_ce=0 indefinitely freezes all outputs, except the start strobes, which still self-clear.
- With pix_ce tied high, the defaults reproduce standard 640x480@60 timing at a 25 MHz clk.

## Configuration
- VTG_FRAME_CNT_EN defined:
  - The frame_cnt port exists.
  - It increments by 1, wrapping 0xFFFF→0, on the same edge frame_start is set.
- Not defined: the port and its register are absent. No other behaviour changes.

## Structure
- Package vga_timing_pkg holds:
  - Default 640x480 timing constants.
  - An 800x600@72 set for the 50 MHz board.
  - Helper constants H_TOTAL/V_TOTAL derived from the parameters.
- Sub-module vga_axis_counter (parameters TOTAL, ACTIVE, SYNC_START, SYNC_LEN, CW; inputs en, clr; outputs count, wrap, blank, sync) is instantiated twice:
  - Horizontal instance: en=pix_ce.
  - Vertical instance: en=pix_ce & h.wrap.

## Test plan
- Reset: assert clr, release, no pix_ce → hsync=1, vsync=1, video_on=0, hblank=vblank=1, pixel_x=pixel_y=0.
- pix_ce=1 continuously, defaults → per line: video_on high 640 clks, hsync low 96 clks starting at pixel 656, line period 800 clks; first frame_start one clk after the first ce.
- pix_ce 1-in-4 → outputs change only on ce edges, line period 3200 clks, line_start width exactly 1 clk.
- Run 800×525 ce pulses → frame_start every 420000 ce; vsync low on lines 490–491; pixel_y reaches 479 then is held at 0 during vblank.
- clr asserted at (x=300, y=200) → next-cycle outputs match reset values; first ce after release gives pixel_x=0 and frame_start=1.
- HS_POL=1, VS_POL=1 with VTG_FRAME_CNT_EN → hsync high during sync window, idle low; frame_cnt = 3 after the third frame_start.
